// File: rtl/usb_pulpino_mailbox_pkg.sv
// Shared types and constants for the USB<->PULPino GPIO mailbox.
// Holds the rx sequencer states, status bit indices and GPIO bit map.
package usb_pulpino_mailbox_pkg;

  typedef enum logic {
    IDLE,
    WAIT_ACK
  } rx_state_e;

  localparam int STAT_W       = 3;
  localparam int STAT_TIMEOUT = 0;
  localparam int STAT_OVF     = 1;
  localparam int STAT_PROTO   = 2;

  localparam int GPIO_DATA_LSB  = 0;
  localparam int GPIO_DATA_MSB  = 7;
  localparam int GPIO_RX_ACK    = 8;
  localparam int GPIO_TX_TOGGLE = 9;

endpackage

// File: rtl/usb_pulpino_mailbox_ctrl_if.sv
// Mailbox bus: USB register side strobes/levels plus PULPino GPIO side.
// slave = the controller, master = the USB block and PULPino driving it.
interface usb_pulpino_mailbox_ctrl_if #(
  parameter int LVL_WIDTH = 4
);

  logic                 usb_wr_i;
  logic [7:0]           usb_wr_data_i;
  logic                 usb_rd_i;
  logic [7:0]           usb_rd_data_o;
  logic                 usb_rd_valid_o;
  logic [LVL_WIDTH-1:0] rx_level_o;
  logic [LVL_WIDTH-1:0] tx_level_o;
  logic [7:0]           p_rx_data_o;
  logic                 p_rx_toggle_o;
  logic                 p_rx_ack_i;
  logic [7:0]           p_tx_data_i;
  logic                 p_tx_toggle_i;
  logic                 p_tx_ack_o;
  logic [2:0]           status_o;
  logic                 status_clr_i;

  modport slave (
    input  usb_wr_i, usb_wr_data_i, usb_rd_i,
    input  p_rx_ack_i, p_tx_data_i, p_tx_toggle_i,
    input  status_clr_i,
    output usb_rd_data_o, usb_rd_valid_o,
    output rx_level_o, tx_level_o,
    output p_rx_data_o, p_rx_toggle_o, p_tx_ack_o,
    output status_o
  );

  modport master (
    output usb_wr_i, usb_wr_data_i, usb_rd_i,
    output p_rx_ack_i, p_tx_data_i, p_tx_toggle_i,
    output status_clr_i,
    input  usb_rd_data_o, usb_rd_valid_o,
    input  rx_level_o, tx_level_o,
    input  p_rx_data_o, p_rx_toggle_o, p_tx_ack_o,
    input  status_o
  );

endinterface

// File: rtl/usb_pulpino_mailbox_ctrl_fifo.sv
// mailbox_byte_fifo: 8-bit synchronous FIFO, head shown combinationally.
// Ports: push/pop strobes, data in/out, full, empty, level.
module mailbox_byte_fifo #(
  parameter int DEPTH     = 8,
  parameter int LVL_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push_i,
  input  logic                 pop_i,
  input  logic [7:0]           data_i,
  output logic [7:0]           data_o,
  output logic                 full_o,
  output logic                 empty_o,
  output logic [LVL_WIDTH-1:0] level_o
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]           mem [DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [LVL_WIDTH-1:0] cnt;
  logic                 do_push;
  logic                 do_pop;

  assign full_o  = (cnt == LVL_WIDTH'(DEPTH));
  assign empty_o = (cnt == '0);
  assign level_o = cnt;
  assign data_o  = mem[rd_ptr];

  // a pop in the same cycle frees the slot a full push needs
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push & ~do_pop) cnt <= cnt + LVL_WIDTH'(1);
      if (do_pop & ~do_push) cnt <= cnt - LVL_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= data_i;
  end

endmodule

// File: rtl/usb_pulpino_mailbox_ctrl.sv
// Sequences the byte mailbox between USB registers and PULPino GPIO.
// Ports: clk, reset_i (sync, active high), bus (mailbox interface).
module usb_pulpino_mailbox_ctrl
  import usb_pulpino_mailbox_pkg::*;
#(
  parameter int pDEPTH     = 8,
  parameter int pLVL_WIDTH = 4,
  parameter int pTIMEOUT   = 1000000
) (
  input logic                       clk,
  input logic                       reset_i,
  usb_pulpino_mailbox_ctrl_if.slave bus
);

  localparam int CNT_W = $clog2(pTIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(pTIMEOUT - 1);

  rx_state_e        state_q;
  rx_state_e        state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  logic ack_q;
  logic ttog_q;
  logic pend_q;
  logic p_tog_q;
  logic tx_ack_q;
  logic [7:0] p_data_q;
  logic [7:0] rd_hold_q;
  logic [STAT_W-1:0] status_q;
  logic [STAT_W-1:0] status_set;

  logic rx_full, rx_empty;
  logic tx_full, tx_empty;
  logic [7:0] rx_head, tx_head;
  logic [pLVL_WIDTH-1:0] rx_level, tx_level;

  logic ack_edge, tx_edge;
  logic rx_push, rx_pop, tx_push;
  logic timeout, rx_proto;

  assign ack_edge = bus.p_rx_ack_i ^ ack_q;
  assign tx_edge  = bus.p_tx_toggle_i ^ ttog_q;
  assign rx_push  = bus.usb_wr_i & ~rx_full;
  // full tx fifo still takes the byte when USB pops this cycle
  assign tx_push  = pend_q & (~tx_full | bus.usb_rd_i);

  mailbox_byte_fifo #(
    .DEPTH     (pDEPTH),
    .LVL_WIDTH (pLVL_WIDTH)
  ) u_rx_fifo (
    .clk     (clk),
    .rst     (reset_i),
    .push_i  (rx_push),
    .pop_i   (rx_pop),
    .data_i  (bus.usb_wr_data_i),
    .data_o  (rx_head),
    .full_o  (rx_full),
    .empty_o (rx_empty),
    .level_o (rx_level)
  );

  mailbox_byte_fifo #(
    .DEPTH     (pDEPTH),
    .LVL_WIDTH (pLVL_WIDTH)
  ) u_tx_fifo (
    .clk     (clk),
    .rst     (reset_i),
    .push_i  (tx_push),
    .pop_i   (bus.usb_rd_i),
    .data_i  (bus.p_tx_data_i),
    .data_o  (tx_head),
    .full_o  (tx_full),
    .empty_o (tx_empty),
    .level_o (tx_level)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rx_pop   = 1'b0;
    timeout  = 1'b0;
    rx_proto = 1'b0;
    unique case (state_q)
      IDLE: begin
        rx_proto = ack_edge;
        if (!rx_empty) begin
          rx_pop  = 1'b1;
          cnt_d   = '0;
          state_d = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (ack_edge) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          timeout = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    status_set               = '0;
    status_set[STAT_TIMEOUT] = timeout;
    status_set[STAT_OVF]     = bus.usb_wr_i & rx_full;
    status_set[STAT_PROTO]   = rx_proto | (tx_edge & pend_q);
  end

  always_ff @(posedge clk) begin
    if (reset_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      ack_q     <= 1'b0;
      ttog_q    <= 1'b0;
      pend_q    <= 1'b0;
      p_tog_q   <= 1'b0;
      tx_ack_q  <= 1'b0;
      p_data_q  <= '0;
      rd_hold_q <= '0;
      status_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_q   <= bus.p_rx_ack_i;
      ttog_q  <= bus.p_tx_toggle_i;
      pend_q  <= tx_edge | (pend_q & ~tx_push);
      if (rx_pop) begin
        p_data_q <= rx_head;
        p_tog_q  <= ~p_tog_q;
      end
      if (tx_push) tx_ack_q <= ~tx_ack_q;
      // last popped byte stays visible once the fifo drains
      if (bus.usb_rd_i & ~tx_empty) rd_hold_q <= tx_head;
      if (bus.status_clr_i) status_q <= '0;
      else                  status_q <= status_q | status_set;
    end
  end

  assign bus.usb_rd_data_o  = tx_empty ? rd_hold_q : tx_head;
  assign bus.usb_rd_valid_o = ~tx_empty;
  assign bus.rx_level_o     = rx_level;
  assign bus.tx_level_o     = tx_level;
  assign bus.p_rx_data_o    = p_data_q;
  assign bus.p_rx_toggle_o  = p_tog_q;
  assign bus.p_tx_ack_o     = tx_ack_q;
  assign bus.status_o       = status_q;

endmodule

// File: tb/tb_usb_pulpino_mailbox_ctrl.sv
// Bench for usb_pulpino_mailbox_ctrl: directed scenarios then random
// traffic, every cycle compared against a queue-based reference model.
module tb_usb_pulpino_mailbox_ctrl;
  import usb_pulpino_mailbox_pkg::*;

  localparam int DEPTH = 8;
  localparam int LVLW  = 4;
  localparam int TO    = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  usb_pulpino_mailbox_ctrl_if #(.LVL_WIDTH(LVLW)) bus ();

  usb_pulpino_mailbox_ctrl #(
    .pDEPTH     (DEPTH),
    .pLVL_WIDTH (LVLW),
    .pTIMEOUT   (TO)
  ) dut (
    .clk     (clk),
    .reset_i (rst),
    .bus     (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  logic [7:0] rx_q[$];
  logic [7:0] tx_q[$];
  logic       m_wait;
  int         m_age;
  logic [7:0] m_pdata;
  logic       m_ptog;
  logic       m_txack;
  logic       m_pend;
  logic [7:0] m_last;
  logic [2:0] m_stat;
  logic       m_ack_prev;
  logic       m_tog_prev;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", tag, got, exp);
  endtask

  task automatic model_reset();
    rx_q.delete();
    tx_q.delete();
    m_wait     = 1'b0;
    m_age      = 0;
    m_pdata    = '0;
    m_ptog     = 1'b0;
    m_txack    = 1'b0;
    m_pend     = 1'b0;
    m_last     = '0;
    m_stat     = '0;
    m_ack_prev = 1'b0;
    m_tog_prev = 1'b0;
  endtask

  // Advance the model by one clock edge using the inputs now applied.
  task automatic model_step();
    logic ack_ev, tx_ev, can;
    logic [2:0] sets;
    int rx_n, tx_n;
    if (rst) begin
      model_reset();
      return;
    end
    ack_ev = bus.p_rx_ack_i != m_ack_prev;
    tx_ev  = bus.p_tx_toggle_i != m_tog_prev;
    rx_n   = rx_q.size();
    tx_n   = tx_q.size();
    sets   = '0;
    if (bus.usb_wr_i) begin
      if (rx_n == DEPTH) sets[STAT_OVF] = 1'b1;
      else rx_q.push_back(bus.usb_wr_data_i);
    end
    if (!m_wait) begin
      if (ack_ev) sets[STAT_PROTO] = 1'b1;
      if (rx_n > 0) begin
        m_pdata = rx_q.pop_front();
        m_ptog  = ~m_ptog;
        m_wait  = 1'b1;
        m_age   = 0;
      end
    end else begin
      m_age++;
      if (ack_ev) m_wait = 1'b0;
      else if (m_age == TO) begin
        sets[STAT_TIMEOUT] = 1'b1;
        m_wait = 1'b0;
      end
    end
    can = m_pend && (tx_n < DEPTH || bus.usb_rd_i);
    if (bus.usb_rd_i && tx_n > 0) m_last = tx_q.pop_front();
    if (can) begin
      tx_q.push_back(bus.p_tx_data_i);
      m_txack = ~m_txack;
    end
    if (tx_ev && m_pend) sets[STAT_PROTO] = 1'b1;
    m_pend = tx_ev || (m_pend && !can);
    if (bus.status_clr_i) m_stat = '0;
    else m_stat = m_stat | sets;
    m_ack_prev = bus.p_rx_ack_i;
    m_tog_prev = bus.p_tx_toggle_i;
  endtask

  task automatic compare_all();
    logic [7:0] exp_rd;
    exp_rd = m_last;
    if (tx_q.size() > 0) exp_rd = tx_q[0];
    check("rx_data", bus.p_rx_data_o, m_pdata);
    check("rx_tog", bus.p_rx_toggle_o, m_ptog);
    check("tx_ack", bus.p_tx_ack_o, m_txack);
    check("status", bus.status_o, m_stat);
    check("rx_lvl", bus.rx_level_o, rx_q.size());
    check("tx_lvl", bus.tx_level_o, tx_q.size());
    check("rd_valid", bus.usb_rd_valid_o, tx_q.size() != 0);
    check("rd_data", bus.usb_rd_data_o, exp_rd);
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
    bus.usb_wr_i     = 1'b0;
    bus.usb_rd_i     = 1'b0;
    bus.status_clr_i = 1'b0;
  endtask

  logic exp_ack;
  logic acked_tog;

  initial begin
    rst               = 1'b1;
    bus.usb_wr_i      = 1'b0;
    bus.usb_wr_data_i = '0;
    bus.usb_rd_i      = 1'b0;
    bus.p_rx_ack_i    = 1'b0;
    bus.p_tx_data_i   = '0;
    bus.p_tx_toggle_i = 1'b0;
    bus.status_clr_i  = 1'b0;
    model_reset();
    cycle();
    cycle();
    rst = 1'b0;
    check("rst_status", bus.status_o, 3'd0);
    check("rst_rxlvl", bus.rx_level_o, 0);
    check("rst_txlvl", bus.tx_level_o, 0);
    check("rst_rxtog", bus.p_rx_toggle_o, 0);
    check("rst_valid", bus.usb_rd_valid_o, 0);

    bus.usb_wr_i      = 1'b1;
    bus.usb_wr_data_i = 8'hA5;
    cycle();
    check("a5_lvl1", bus.rx_level_o, 1);
    cycle();
    check("a5_data", bus.p_rx_data_o, 8'hA5);
    check("a5_tog", bus.p_rx_toggle_o, 1);
    bus.p_rx_ack_i = ~bus.p_rx_ack_i;
    cycle();
    check("a5_lvl0", bus.rx_level_o, 0);
    check("a5_stat", bus.status_o, 3'd0);

    for (int i = 0; i < 9; i++) begin
      bus.usb_wr_i      = 1'b1;
      bus.usb_wr_data_i = 8'(i);
      cycle();
    end
    check("fill_head", bus.p_rx_data_o, 8'h00);
    check("fill_lvl", bus.rx_level_o, 8);
    check("fill_noovf", bus.status_o[STAT_OVF], 0);
    bus.usb_wr_i      = 1'b1;
    bus.usb_wr_data_i = 8'h09;
    cycle();
    check("ovf_set", bus.status_o[STAT_OVF], 1);
    check("ovf_lvl", bus.rx_level_o, 8);
    for (int i = 1; i <= 8; i++) begin
      bus.p_rx_ack_i = ~bus.p_rx_ack_i;
      cycle();
      cycle();
      check("rx_order", bus.p_rx_data_o, 8'(i));
    end
    bus.p_rx_ack_i = ~bus.p_rx_ack_i;
    cycle();
    bus.status_clr_i = 1'b1;
    cycle();
    check("clr1", bus.status_o, 3'd0);

    bus.usb_wr_i      = 1'b1;
    bus.usb_wr_data_i = 8'h11;
    cycle();
    bus.usb_wr_i      = 1'b1;
    bus.usb_wr_data_i = 8'h22;
    cycle();
    check("to_first", bus.p_rx_data_o, 8'h11);
    repeat (15) cycle();
    check("to_early", bus.status_o[STAT_TIMEOUT], 0);
    cycle();
    check("to_set", bus.status_o[STAT_TIMEOUT], 1);
    cycle();
    check("to_next", bus.p_rx_data_o, 8'h22);
    bus.status_clr_i = 1'b1;
    cycle();
    check("to_clr", bus.status_o, 3'd0);
    bus.p_rx_ack_i = ~bus.p_rx_ack_i;
    cycle();

    exp_ack           = 1'b0;
    bus.p_tx_data_i   = 8'h3C;
    bus.p_tx_toggle_i = ~bus.p_tx_toggle_i;
    cycle();
    cycle();
    exp_ack = ~exp_ack;
    check("tx3c_ack", bus.p_tx_ack_o, exp_ack);
    check("tx3c_valid", bus.usb_rd_valid_o, 1);
    check("tx3c_data", bus.usb_rd_data_o, 8'h3C);
    bus.usb_rd_i = 1'b1;
    cycle();
    check("tx3c_pop", bus.usb_rd_valid_o, 0);
    check("tx3c_hold", bus.usb_rd_data_o, 8'h3C);

    for (int i = 0; i < 8; i++) begin
      bus.p_tx_data_i   = 8'(8'h80 + i);
      bus.p_tx_toggle_i = ~bus.p_tx_toggle_i;
      cycle();
      cycle();
      exp_ack = ~exp_ack;
    end
    check("txf_ack", bus.p_tx_ack_o, exp_ack);
    check("txf_lvl", bus.tx_level_o, 8);
    bus.p_tx_data_i   = 8'h99;
    bus.p_tx_toggle_i = ~bus.p_tx_toggle_i;
    repeat (3) cycle();
    check("txf_noack", bus.p_tx_ack_o, exp_ack);
    bus.usb_rd_i = 1'b1;
    cycle();
    exp_ack = ~exp_ack;
    check("txf_ack9", bus.p_tx_ack_o, exp_ack);
    check("txf_lvl9", bus.tx_level_o, 8);
    check("txf_head", bus.usb_rd_data_o, 8'h81);

    bus.p_rx_ack_i = ~bus.p_rx_ack_i;
    cycle();
    check("proto", bus.status_o[STAT_PROTO], 1);
    bus.status_clr_i = 1'b1;
    cycle();

    bus.usb_wr_i      = 1'b1;
    bus.usb_wr_data_i = 8'h5A;
    cycle();
    cycle();
    check("wa_data", bus.p_rx_data_o, 8'h5A);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check("mr_data", bus.p_rx_data_o, 8'h00);
    check("mr_tog", bus.p_rx_toggle_o, 0);
    check("mr_ack", bus.p_tx_ack_o, 0);
    check("mr_stat", bus.status_o, 3'd0);
    check("mr_rxlvl", bus.rx_level_o, 0);
    check("mr_txlvl", bus.tx_level_o, 0);
    check("mr_valid", bus.usb_rd_valid_o, 0);
    check("mr_rddata", bus.usb_rd_data_o, 8'h00);

    acked_tog = m_ptog;
    for (int n = 0; n < 3000; n++) begin
      rst               = ($urandom_range(0, 499) == 0);
      bus.usb_wr_i      = ($urandom_range(0, 2) == 0);
      bus.usb_wr_data_i = 8'($urandom);
      bus.usb_rd_i      = ($urandom_range(0, 2) == 0);
      bus.status_clr_i  = ($urandom_range(0, 39) == 0);
      if (m_ptog != acked_tog && $urandom_range(0, 4) == 0) begin
        bus.p_rx_ack_i = ~bus.p_rx_ack_i;
        acked_tog      = m_ptog;
      end else if ($urandom_range(0, 99) == 0) begin
        bus.p_rx_ack_i = ~bus.p_rx_ack_i;
      end
      if (bus.p_tx_toggle_i == m_txack && $urandom_range(0, 3) == 0) begin
        bus.p_tx_data_i   = 8'($urandom);
        bus.p_tx_toggle_i = ~bus.p_tx_toggle_i;
      end else if ($urandom_range(0, 149) == 0) begin
        bus.p_tx_toggle_i = ~bus.p_tx_toggle_i;
      end
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/usb_pulpino_mailbox_ctrl.md
Name: usb_pulpino_mailbox_ctrl

Overview:
- Sequences the byte-wide USB↔PULPino GPIO mailbox using toggle ("flicker") handshakes.
- Buffers bytes in both directions, presents USB→PULPino bytes one at a time, and acknowledges PULPino→USB bytes.
- Flags timeout, overflow and protocol errors.
- Sits between the USB register block (already in the pulpino_clk domain) and the PULPino gpio_in/gpio_out bits.

Parameters:
- pDEPTH, 8: depth of each byte FIFO; power of two, ≥2.
- pLVL_WIDTH, 4: width of level outputs; equals log2(pDEPTH)+1.
- pTIMEOUT, 1000000: cycles WAIT_ACK may last before abort; ≥2.

Ports:
- clk  in  1  pulpino_clk
- reset_i  in  1  synchronous, active-high reset
- usb_wr_i  in  1  one-cycle push strobe, USB→PULPino
- usb_wr_data_i  in  8  byte to push
- usb_rd_i  in  1  one-cycle pop strobe, PULPino→USB
- usb_rd_data_o  out  8  head of tx FIFO (valid when usb_rd_valid_o)
- usb_rd_valid_o  out  1  tx FIFO non-empty
- rx_level_o  out  pLVL_WIDTH  rx FIFO occupancy
- tx_level_o  out  pLVL_WIDTH  tx FIFO occupancy
- p_rx_data_o  out  8  byte presented to PULPino (gpio_in[7:0])
- p_rx_toggle_o  out  1  flips when a new byte is presented (usb_write_flicker)
- p_rx_ack_i  in  1  PULPino ack toggle (gpio_out[8])
- p_tx_data_i  in  8  PULPino byte (gpio_out[7:0])
- p_tx_toggle_i  in  1  PULPino byte-valid toggle (gpio_out[9])
- p_tx_ack_o  out  1  flips when the PULPino byte is accepted (usb_read_flicker)
- status_o  out  3  sticky: [0] timeout, [1] rx overflow, [2] protocol error
- status_clr_i  in  1  clears status_o

Behaviour:
- Single clock. All registers reset synchronously when reset_i=1.
- Reset values:
  - Outputs: all 0. Both FIFOs empty. State IDLE.
  - Timeout counter: 0.
  - Edge-detect registers for p_rx_ack_i and p_tx_toggle_i: 0.
- Reset mid-operation: all in-flight and buffered bytes are discarded.
- Edge detect: edge = input XOR its registered previous value. The previous value updates every cycle.
- Rx FIFO (USB→PULPino):
  - usb_wr_i pushes when not full.
  - If full, the byte is dropped and status_o[1] is set.
  - Level updates 1 cycle after the strobe.
- Rx sequencer, two states:
  - IDLE: if rx FIFO is non-empty, next cycle:
    - p_rx_data_o <= head
    - pop the FIFO
    - flip p_rx_toggle_o
    - clear the counter
    - go to WAIT_ACK
  - First-byte latency: usb_wr_i at cycle N → level 1 at N+1 → data and toggle visible at N+2.
  - WAIT_ACK: counter increments every cycle.
    - p_rx_ack_i edge → IDLE next cycle.
    - Counter reaches pTIMEOUT-1 with no edge → set status_o[0] and go to IDLE. That byte is lost.
    - Ack edge and timeout in the same cycle: the ack wins; no timeout.
  - p_rx_ack_i edge while IDLE → set status_o[2]; otherwise ignored.
  - p_rx_data_o holds its value until the next presentation.
- Tx path (PULPino→USB):
  - On a p_tx_toggle_i edge, a pending flag is set.
  - Pending and tx FIFO not full: push p_tx_data_i and flip p_tx_ack_o in the same cycle, then clear pending.
  - Pending and FIFO full: the ack is deferred. PULPino holds its data until the ack.
  - Full FIFO with usb_rd_i and pending in the same cycle: pop and push both occur; the ack flips that cycle.
  - New p_tx_toggle_i edge while already pending → set status_o[2]; still only one push.
- usb_rd_i pops when non-empty. When empty it is ignored and usb_rd_data_o keeps its value.
- FIFO push and pop in the same cycle: level is unchanged. Pointers wrap modulo pDEPTH.
- Status:
  - status_clr_i has priority over setting in the same cycle; the set is lost.
  - Each status bit is sticky until status_clr_i or reset.

Decomposition:
- Package usb_pulpino_mailbox_pkg holds:
  - state enum {IDLE, WAIT_ACK}
  - status bit indices (STAT_TIMEOUT=0, STAT_OVF=1, STAT_PROTO=2)
  - GPIO bit positions (data 7:0, rx ack 8, tx toggle 9)
- One sub-module: mailbox_byte_fifo, 8-bit synchronous FIFO with parameters DEPTH and LVL_WIDTH and outputs full/empty/level. Instantiated twice.

Test Plan:
- Reset, then push 0xA5 → p_rx_data_o=0xA5 and p_rx_toggle_o 0→1 two cycles later. Toggle p_rx_ack_i → IDLE; rx_level_o=0.
- Push 9 bytes 0x00..0x08 into empty rx FIFO with the PULPino not acking (pDEPTH=8) → 0x00 presented, 0x01..0x08 buffered, no overflow. A 10th push sets status_o[1]. Ack 8 times → bytes arrive in order 0x01..0x08.
- pTIMEOUT=16, present a byte and never ack → status_o[0]=1 exactly 16 cycles after entering WAIT_ACK; the next byte is presented. status_clr_i → status_o=0.
- PULPino sends 0x3C via toggle → p_tx_ack_o flips; usb_rd_valid_o=1 with usb_rd_data_o=0x3C; usb_rd_i → valid=0.
- Fill tx FIFO with 8 bytes, then send a 9th → no ack. usb_rd_i → in the same cycle the 9th byte is pushed and the ack flips; tx_level_o stays 8.
- Toggle p_rx_ack_i while IDLE → status_o[2]=1. Assert reset_i while in WAIT_ACK → next cycle all outputs 0 and both levels 0.
